fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Frame controller between audio_codec_data and fft_stream. Decimates the codec sample stream and
//  packs samples into W_OUT-bit words. Feeds exactly FRAME_LEN words per frame into the FFT.
//  Waits for the FFT result frame (last beat) before starting the next frame.
//  Replaces the free-running decimation glue; adds drop/timeout accounting and start/stop control.
// PARAMETERS
//  W_IN        16      codec sample width (two's complement)
//  W_OUT       32      FFT input word width
//  LSB_PAD     8       zero bits appended below the sample; remaining MSBs are sign extension
//  DECIM_LOG2  6       keep 1 of every 2**DECIM_LOG2 samples (0 = keep all)
//  FRAME_LEN   1024    FFT input words per frame (power of 2)
//  TIMEOUT_CYC 2**20   max cycles in WAIT_RES before giving up
// PORTS
//  clk          in   1      adc clock domain (18.432 MHz)
//  reset        in   1      synchronous, active-high
//  enable       in   1      level; run frames while high
//  single_shot  in   1      1 = one frame per enable rise, then IDLE
//  clear_flags  in   1      pulse; clears overrun, timeout, drop_count
//  aud_data     in   W_IN   codec sample
//  aud_valid    in   1      one-cycle strobe per sample; codec side has no backpressure
//  fft_data     out  W_OUT  {sign-ext, aud_data, LSB_PAD zeros}
//  fft_valid    out  1      to fft_stream x.valid
//  fft_ready    in   1      from fft_stream x.ready
//  res_valid    in   1      fft_stream y.valid (monitor only)
//  res_ready    in   1      y.ready as seen by the downstream consumer
//  res_last     in   1      y.data[MSB], last bin of the result frame
//  busy         out  1      state != IDLE
//  frame_done   out  1      one-cycle pulse on result last-beat handshake
//  frame_count  out  16     completed frames, wraps
//  drop_count   out  16     kept samples lost to backpressure, saturates at 16'hFFFF
//  overrun      out  1      sticky; set on any drop
//  timeout      out  1      sticky; set on WAIT_RES timeout
//  state_dbg    out  2      current state encoding
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, counters and flags 0; fft_valid drops at the reset edge.
//  States: IDLE=0, FILL=1, WAIT_RES=2.
//   IDLE -> FILL when enable=1 (single_shot: only on enable 0->1 edge).
//    On entry, clear decim_idx and load_cnt.
//   FILL -> WAIT_RES when load_cnt==FRAME_LEN and the output register is empty,
//    or is emptying this cycle (fft_valid&&fft_ready).
//   WAIT_RES -> FILL on res_valid&&res_ready&&res_last, if enable=1 and single_shot=0; else -> IDLE.
//    Same cycle: frame_done=1, frame_count++.
//   WAIT_RES timeout: wait_cnt reaches TIMEOUT_CYC-1 -> timeout=1 -> IDLE; no frame_done.
//  enable low is sampled only in IDLE and at WAIT_RES exit. A started frame is always completed
//   (never a partial frame into the FFT).
//  Decimation, FILL only: decim_idx++ (wrapping) on each aud_valid.
//   Sample is kept when decim_idx == 2**DECIM_LOG2-1.
//   aud_valid outside FILL, or after load_cnt==FRAME_LEN, is ignored.
//  Output register: kept sample loads with 1-cycle latency (fft_valid=1 at the next edge); load_cnt++.
//   Held stable until fft_valid&&fft_ready.
//   Kept sample while register full and not emptying this cycle: sample discarded;
//    drop_count++ (saturating), overrun=1, load_cnt unchanged.
//   Handshake and new kept sample in the same cycle: load allowed, no drop.
//  clear_flags vs. a same-cycle drop or timeout: set wins; drop_count becomes 1.
//  load_cnt width clog2(FRAME_LEN)+1; wait_cnt width clog2(TIMEOUT_CYC).
//  Reset mid-FILL/WAIT_RES: immediate return to IDLE. fft_stream shares the same reset.
// STRUCTURE
//  fft_ctrl_pkg: state_t enum (IDLE, FILL, WAIT_RES), pack_sample() function, counter width constants.
//  Sub-module sample_decimator: decim_idx counter with clear input; outputs keep strobe.
//  Remainder (FSM, output register, counters) stays in this module.
// TESTING
//  1) DECIM_LOG2=6, fft_ready=1, enable=1: 65536 aud_valid strobes -> exactly 1024 fft beats, 0 drops.
//     aud_data=16'h8001 -> fft_data=32'hFF800100.
//  2) Result last beat after frame -> frame_done pulse, frame_count=1, FILL re-entered next cycle.
//  3) fft_ready=0 across 3 kept samples -> fft_data holds first sample, drop_count=2, overrun=1.
//     clear_flags -> counts cleared.
//  4) single_shot=1, enable held high -> exactly one frame, then IDLE, busy=0.
//     Drop and re-raise enable -> second frame.
//  5) TIMEOUT_CYC=100, no res_last -> timeout=1 at cycle 100 of WAIT_RES, IDLE, frame_count unchanged.
//  6) reset asserted at load_cnt=500 -> all outputs 0 next edge; after release, next frame counts from 0.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame sequencer: state encoding,
// counter widths and the codec-sample to FFT-word packing function.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  localparam int PACK_W      = 64;
  localparam int FRAME_CNT_W = 16;
  localparam int DROP_CNT_W  = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  // Caller sign-extends the sample to PACK_W and truncates the result to the FFT word width.
  function automatic logic [PACK_W-1:0] pack_sample(input logic [PACK_W-1:0] sample_sext,
                                                    input int lsb_pad);
    return sample_sext << lsb_pad;
  endfunction

  function automatic int cnt_w(input longint n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_sample_decimator.sv
// Keeps one of every 2**DECIM_LOG2 accepted codec strobes; clear restarts the
// phase so every frame starts from the same decimation alignment.
module sample_decimator #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic sample_valid,
  output logic keep
);

  localparam int IDX_W = (DECIM_LOG2 < 1) ? 1 : DECIM_LOG2;

  logic [IDX_W-1:0] decim_idx_q;
  logic [IDX_W-1:0] decim_idx_d;
  logic             at_last;

  generate
    if (DECIM_LOG2 == 0) begin : g_keep_all
      assign at_last = 1'b1;
    end else begin : g_decim
      assign at_last = (decim_idx_q == {IDX_W{1'b1}});
    end
  endgenerate

  always_comb begin
    decim_idx_d = decim_idx_q;
    if (clear) begin
      decim_idx_d = '0;
    end else if (count_en && sample_valid) begin
      decim_idx_d = decim_idx_q + 1'b1;
    end
  end

  assign keep = count_en && sample_valid && at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      decim_idx_q <= '0;
    end else begin
      decim_idx_q <= decim_idx_d;
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: decimates codec samples, feeds exactly FRAME_LEN packed words
// to the FFT, then waits for the result frame's last beat (or a timeout).
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int W_IN        = 16,
  parameter int W_OUT       = 32,
  parameter int LSB_PAD     = 8,
  parameter int DECIM_LOG2  = 6,
  parameter int FRAME_LEN   = 1024,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             single_shot,
  input  logic             clear_flags,
  input  logic [W_IN-1:0]  aud_data,
  input  logic             aud_valid,
  output logic [W_OUT-1:0] fft_data,
  output logic             fft_valid,
  input  logic             fft_ready,
  input  logic             res_valid,
  input  logic             res_ready,
  input  logic             res_last,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic [15:0]      drop_count,
  output logic             overrun,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam int LOAD_W = $clog2(FRAME_LEN) + 1;
  localparam int WAIT_W = cnt_w(TIMEOUT_CYC);
  localparam logic [LOAD_W-1:0] LOAD_FULL = LOAD_W'(FRAME_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_t                 state_q, state_d;
  logic                   enable_prev_q, enable_prev_d;
  logic                   out_valid_q, out_valid_d;
  logic [W_OUT-1:0]       out_data_q, out_data_d;
  logic [LOAD_W-1:0]      load_cnt_q, load_cnt_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic                   frame_done_q, frame_done_d;

  logic              emptying;
  logic              count_en;
  logic              keep;
  logic              load_ok;
  logic              drop;
  logic              fill_entry;
  logic              timeout_set;
  logic              res_last_hs;
  logic [PACK_W-1:0] sample_sext;

  assign emptying    = out_valid_q && fft_ready;
  assign count_en    = (state_q == FILL) && (load_cnt_q != LOAD_FULL);
  assign res_last_hs = res_valid && res_ready && res_last;
  assign sample_sext = PACK_W'($signed(aud_data));

  sample_decimator #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_decim (
    .clk          (clk),
    .reset        (reset),
    .clear        (fill_entry),
    .count_en     (count_en),
    .sample_valid (aud_valid),
    .keep         (keep)
  );

  always_comb begin
    state_d       = state_q;
    enable_prev_d = enable;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    load_cnt_d    = load_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    frame_done_d  = 1'b0;
    fill_entry    = 1'b0;
    timeout_set   = 1'b0;
    load_ok       = keep && (!out_valid_q || emptying);
    drop          = keep && !load_ok;

    // A kept sample may reuse the register in the same cycle it is being drained.
    if (load_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = W_OUT'(pack_sample(sample_sext, LSB_PAD));
      load_cnt_d  = load_cnt_q + 1'b1;
    end else if (emptying) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable && (!single_shot || !enable_prev_q)) begin
          state_d    = FILL;
          fill_entry = 1'b1;
        end
      end
      FILL: begin
        if ((load_cnt_q == LOAD_FULL) && (!out_valid_q || emptying)) begin
          state_d    = WAIT_RES;
          wait_cnt_d = '0;
        end
      end
      WAIT_RES: begin
        if (res_last_hs) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
          if (enable && !single_shot) begin
            state_d    = FILL;
            fill_entry = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fill_entry) begin
      load_cnt_d = '0;
    end

    // Clear first so a same-cycle drop or timeout still leaves its mark.
    if (clear_flags) begin
      drop_count_d = '0;
      overrun_d    = 1'b0;
      timeout_d    = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_count_d != DROP_MAX) begin
        drop_count_d = drop_count_d + 1'b1;
      end
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      enable_prev_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      load_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_prev_q <= enable_prev_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      load_cnt_q    <= load_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign fft_data    = out_data_q;
  assign fft_valid   = out_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a scaled frame (16 words, decimate by 4)
// and a short timeout; FFT input beats are checked against a scoreboard queue.
module tb_fft_frame_sequencer;

  localparam int W_IN        = 16;
  localparam int W_OUT       = 32;
  localparam int LSB_PAD     = 8;
  localparam int DECIM_LOG2  = 2;
  localparam int DECIM       = 4;
  localparam int FRAME_LEN   = 16;
  localparam int TIMEOUT_CYC = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             single_shot;
  logic             clear_flags;
  logic [W_IN-1:0]  aud_data;
  logic             aud_valid;
  logic [W_OUT-1:0] fft_data;
  logic             fft_valid;
  logic             fft_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_last;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic [15:0]      drop_count;
  logic             overrun;
  logic             timeout;
  logic [1:0]       state_dbg;

  int          pass_cnt  = 0;
  int          check_cnt = 0;
  logic [31:0] exp_q[$];
  int          beat_cnt   = 0;
  int          strobe_idx = 0;
  int          kept_cnt   = 0;
  logic [31:0] held_word;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .W_IN        (W_IN),
    .W_OUT       (W_OUT),
    .LSB_PAD     (LSB_PAD),
    .DECIM_LOG2  (DECIM_LOG2),
    .FRAME_LEN   (FRAME_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .single_shot (single_shot),
    .clear_flags (clear_flags),
    .aud_data    (aud_data),
    .aud_valid   (aud_valid),
    .fft_data    (fft_data),
    .fft_valid   (fft_valid),
    .fft_ready   (fft_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_last    (res_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .overrun     (overrun),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  function automatic logic [31:0] exp_word(input logic [15:0] d);
    return {{8{d[15]}}, d, 8'h00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame_model();
    strobe_idx = 0;
    kept_cnt   = 0;
    beat_cnt   = 0;
  endtask

  // One codec strobe followed by an idle cycle; pushes the expected word when it should load.
  task automatic strobe(input logic [15:0] d, input bit loads);
    aud_valid = 1'b1;
    aud_data  = d;
    if ((strobe_idx % DECIM == DECIM - 1) && loads && (kept_cnt < FRAME_LEN)) begin
      exp_q.push_back(exp_word(d));
      kept_cnt++;
    end
    strobe_idx++;
    tick();
    aud_valid = 1'b0;
    tick();
  endtask

  task automatic result_last_beat();
    res_valid = 1'b1;
    res_ready = 1'b1;
    res_last  = 1'b1;
    tick();
    res_valid = 1'b0;
    res_ready = 1'b0;
    res_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && fft_valid && fft_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        check("beat_data", fft_data, exp_q.pop_front());
      end
      beat_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    single_shot = 1'b0;
    clear_flags = 1'b0;
    aud_data    = '0;
    aud_valid   = 1'b0;
    fft_ready   = 1'b0;
    res_valid   = 1'b0;
    res_ready   = 1'b0;
    res_last    = 1'b0;
    repeat (3) tick();

    check("rst_fft_valid", fft_valid, 0);
    check("rst_fft_data", fft_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    tick();

    // Continuous frame with no backpressure; 0x8001 lands on the first kept slot.
    fft_ready = 1'b1;
    enable    = 1'b1;
    start_frame_model();
    tick();
    check("t1_state_fill", state_dbg, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < DECIM * FRAME_LEN; i++) begin
      if (i == DECIM - 1) begin
        aud_valid = 1'b1;
        aud_data  = 16'h8001;
        exp_q.push_back(32'hFF800100);
        kept_cnt++;
        strobe_idx++;
        tick();
        aud_valid = 1'b0;
        check("t1_pack_8001", fft_data, 32'hFF800100);
        check("t1_first_valid", fft_valid, 1);
        tick();
      end else begin
        strobe(16'($urandom()), 1'b1);
      end
    end
    for (int i = 0; i < 8; i++) strobe(16'($urandom()), 1'b1);
    tick();
    check("t1_beats", 32'(beat_cnt), FRAME_LEN);
    check("t1_drops", drop_count, 0);
    check("t1_qsize", 32'(exp_q.size()), 0);
    check("t1_state_wait", state_dbg, 2);

    // Result frame: a non-last beat does nothing, the last beat completes the frame.
    res_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    res_valid = 1'b0;
    res_ready = 1'b0;
    check("t2_nolast_done", frame_done, 0);
    check("t2_nolast_state", state_dbg, 2);
    result_last_beat();
    check("t2_frame_done", frame_done, 1);
    check("t2_frame_count", frame_count, 1);
    check("t2_state_fill", state_dbg, 1);
    tick();
    check("t2_done_pulse", frame_done, 0);

    // Backpressure: first kept sample held, the next two dropped.
    start_frame_model();
    fft_ready = 1'b0;
    for (int i = 0; i < DECIM; i++) strobe(16'($urandom()), 1'b1);
    held_word = exp_q[0];
    for (int i = 0; i < 2 * DECIM; i++) strobe(16'($urandom()), 1'b0);
    check("t3_valid_held", fft_valid, 1);
    check("t3_data_held", fft_data, held_word);
    check("t3_drop_count", drop_count, 2);
    check("t3_overrun", overrun, 1);
    for (int i = 0; i < DECIM - 1; i++) strobe(16'($urandom()), 1'b0);
    aud_valid   = 1'b1;
    aud_data    = 16'($urandom());
    clear_flags = 1'b1;
    strobe_idx++;
    tick();
    aud_valid   = 1'b0;
    clear_flags = 1'b0;
    check("t3_clear_vs_drop_cnt", drop_count, 1);
    check("t3_clear_vs_drop_ovr", overrun, 1);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t3_cleared_cnt", drop_count, 0);
    check("t3_cleared_ovr", overrun, 0);
    check("t3_data_still_held", fft_data, held_word);
    fft_ready = 1'b1;
    tick();
    check("t3_drained_q", 32'(exp_q.size()), 0);
    check("t3_drained_valid", fft_valid, 0);
    for (int i = 0; i < DECIM * (FRAME_LEN - 1); i++) strobe(16'($urandom()), 1'b1);
    check("t3_beats", 32'(beat_cnt), FRAME_LEN);

    // No result arrives: the timeout fires on the 100th WAIT_RES cycle.
    check("t5_state_wait", state_dbg, 2);
    repeat (TIMEOUT_CYC - 1) tick();
    check("t5_pre_timeout", timeout, 0);
    check("t5_pre_state", state_dbg, 2);
    tick();
    enable = 1'b0;
    check("t5_timeout", timeout, 1);
    check("t5_state_idle", state_dbg, 0);
    check("t5_frame_count", frame_count, 1);
    check("t5_no_done", frame_done, 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t5_timeout_cleared", timeout, 0);

    // Single-shot: one frame per enable rise.
    single_shot = 1'b1;
    enable      = 1'b1;
    start_frame_model();
    tick();
    check("t4_state_fill", state_dbg, 1);
    for (int i = 0; i < DECIM * FRAME_LEN; i++) strobe(16'($urandom()), 1'b1);
    check("t4_state_wait", state_dbg, 2);
    check("t4_beats", 32'(beat_cnt), FRAME_LEN);
    result_last_beat();
    check("t4_frame_done", frame_done, 1);
    check("t4_frame_count", frame_count, 2);
    check("t4_state_idle", state_dbg, 0);
    check("t4_busy", busy, 0);
    repeat (5) tick();
    check("t4_stays_idle", state_dbg, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    start_frame_model();
    tick();
    check("t4_rearm_fill", state_dbg, 1);
    check("t4_rearm_busy", busy, 1);

    // Reset in the middle of a frame with a word waiting in the output register.
    for (int i = 0; i < DECIM * (FRAME_LEN / 2) - 1; i++) strobe(16'($urandom()), 1'b1);
    fft_ready = 1'b0;
    strobe(16'($urandom()), 1'b1);
    check("t6_pre_valid", fft_valid, 1);
    check("t6_pre_beats", 32'(beat_cnt), FRAME_LEN / 2 - 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("t6_rst_fft_valid", fft_valid, 0);
    check("t6_rst_fft_data", fft_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_state", state_dbg, 0);
    check("t6_rst_frame_count", frame_count, 0);
    check("t6_rst_drop_count", drop_count, 0);
    check("t6_rst_overrun", overrun, 0);
    reset     = 1'b0;
    fft_ready = 1'b1;
    start_frame_model();
    tick();
    check("t6_restart_fill", state_dbg, 1);
    for (int i = 0; i < DECIM * FRAME_LEN; i++) strobe(16'($urandom()), 1'b1);
    check("t6_beats", 32'(beat_cnt), FRAME_LEN);
    check("t6_state_wait", state_dbg, 2);
    result_last_beat();
    check("t6_frame_count", frame_count, 1);
    check("t6_state_idle", state_dbg, 0);
    check("final_qsize", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
